// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or_src_decode_if.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__or_src_decode_if
//
// Purpose: bundles the signals between the OR-source decoder and its
//          surroundings, which are the raw source lines, the consumer
//          acknowledge and the decoded status.
//
// Signals:
//   A     [WIDTH]  raw source lines, i.e. the terms feeding an OR merge
//   ACK   [1]      consumer acknowledges the index presented on IDX
//   Z     [1]      OR of all pending flags (driven from registered state)
//   VALID [1]      at least one source is pending
//   IDX   [IDXW]   lowest-numbered pending source (0 when none)
//   PEND  [WIDTH]  pending-flag vector
//   LOST  [4]      saturating count of events dropped on already-pending sources
//
// Modports:
//   master : the side that drives A/ACK and observes the status
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu7t5v0__or_src_decode_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
);
    logic [WIDTH-1:0] A;
    logic             ACK;
    logic             Z;
    logic             VALID;
    logic [IDXW-1:0]  IDX;
    logic [WIDTH-1:0] PEND;
    logic [3:0]       LOST;

    modport master (
        output A,
        output ACK,
        input  Z,
        input  VALID,
        input  IDX,
        input  PEND,
        input  LOST
    );

    modport slave (
        input  A,
        input  ACK,
        output Z,
        output VALID,
        output IDX,
        output PEND,
        output LOST
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or_src_decode.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__or_src_decode
//
// Purpose: decodes a merged OR event back to the source(s) that caused it.
//          A rising edge on A[i] latches a pending flag PEND[i]. The consumer
//          reads IDX, which is the lowest pending source, and pulses ACK to
//          retire that source. Each ACK cycle retires one source. Edges that
//          arrive on a source that is already pending are counted in LOST,
//          and LOST saturates at 15.
//
// Ports:
//   CLK       in     rising-edge clock
//   RST       in     synchronous active-high reset
//   VDD, VSS  inout  supply pins with no functional role
//   bus       slave modport of gf180mcu_fd_sc_mcu7t5v0__or_src_decode_if
//                    (A, ACK in; Z, VALID, IDX, PEND, LOST out)
//
// Parameters:
//   WIDTH  number of sources, 2..16
//   IDXW   index width, which must equal $clog2(WIDTH)
//
// Configuration macro:
//   GF180MCU_OR_SRC_DECODE_SYNC2_EN
//     When this macro is defined, each A bit passes through a 2-flop
//     synchronizer before edge detection, and the latency from an edge on A
//     to PEND becomes 3 cycles. When it is undefined, A is sampled directly,
//     the latency is 1 cycle and no synchronizer flops exist.
//
// Z, VALID and IDX are decoded only from the PEND register. No
// combinational path exists from A to any output.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__or_src_decode #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic CLK,
    input  logic RST,
    inout  wire  VDD,
    inout  wire  VSS,
    gf180mcu_fd_sc_mcu7t5v0__or_src_decode_if.slave bus
);

    // Wide enough to hold a population count of WIDTH bits (16 -> 5 bits).
    localparam int CNTW = $clog2(WIDTH + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("WIDTH must be in 2..16");
    end
    if (IDXW != $clog2(WIDTH)) begin : g_bad_idxw
        $error("IDXW must equal $clog2(WIDTH)");
    end

    // The supply pins have no function. Folding them into a net whose name
    // contains "unused" documents that they are deliberately not consumed.
    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Number of set bits in v.
    function automatic logic [CNTW-1:0] count_ones(input logic [WIDTH-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNTW'(v[i]);
        end
        return n;
    endfunction

    // Adds inc to the 4-bit lost counter and clamps the result at 15.
    function automatic logic [3:0] sat_add_lost(input logic [3:0]      cur,
                                                input logic [CNTW-1:0] inc);
        logic [CNTW+4:0] sum;
        sum = (CNTW+5)'(cur) + (CNTW+5)'(inc);
        return (sum > (CNTW+5)'(15)) ? 4'hF : sum[3:0];
    endfunction

    // Returns the index of the lowest set bit, or 0 if no bit is set.
    function automatic logic [IDXW-1:0] lowest_index(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Input sampling: optional 2-flop synchronizer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_s;

`ifdef GF180MCU_OR_SRC_DECODE_SYNC2_EN
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = bus.A;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign a_s = sync2_q;
`else
    assign a_s = bus.A;
`endif

    // ------------------------------------------------------------------
    // Edge detect, pending set/clear, lost-event accounting
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [3:0]       lost_q, lost_d;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] dropped;
    logic             valid;
    logic [IDXW-1:0]  idx;

    assign valid = |pend_q;
    assign idx   = lowest_index(pend_q);

    always_comb begin
        a_d  = a_s;
        rise = a_s & ~a_q;

        // Only one source is retired per ACK cycle. An ACK that arrives
        // while nothing is pending has no effect.
        clr = '0;
        if (bus.ACK && valid) begin
            clr = WIDTH'(1) << idx;
        end

        // OR-ing rise in after the clear gives the set priority. A bit that
        // rises while it is being acknowledged stays pending.
        pend_d = (pend_q & ~clr) | rise;

        // An event is lost only when its source is pending and is not being
        // retired in the same cycle. A bit that is being retired re-arms
        // instead of losing the event.
        dropped = rise & pend_q & ~clr;
        lost_d  = sat_add_lost(lost_q, count_ones(dropped));
    end

    // Reset clears a_q as well. An input held high through reset
    // deassertion therefore appears as a fresh edge on the first cycle
    // after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q    <= '0;
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            a_q    <= a_d;
            pend_q <= pend_d;
            lost_q <= lost_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.PEND  = pend_q;
    assign bus.VALID = valid;
    assign bus.Z     = valid;
    assign bus.IDX   = idx;
    assign bus.LOST  = lost_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__or_src_decode.sv
// ---------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu7t5v0__or_src_decode
//
// Directed scoreboard bench for the default build, where the latency from
// an edge on A to PEND is 1 cycle. Each stimulus cycle pushes the
// hand-computed state expected after the next clock edge. A negedge
// monitor pops those entries and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__or_src_decode;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic clk;
    logic rst;
    wire  vdd;
    wire  vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    gf180mcu_fd_sc_mcu7t5v0__or_src_decode_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    gf180mcu_fd_sc_mcu7t5v0__or_src_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .CLK (clk),
        .RST (rst),
        .VDD (vdd),
        .VSS (vss),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int        cyc;
        string     name;
        logic [7:0] pend;
        logic [2:0] idx;
        logic [3:0] lost;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares the state that follows each edge once that edge
    // has settled.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            if (sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: entry for cycle %0d not checked (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (sb_q[0].cyc == cyc) begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, ".pend"},  32'(bus.PEND),  32'(mon_e.pend));
                chk({mon_e.name, ".idx"},   32'(bus.IDX),   32'(mon_e.idx));
                chk({mon_e.name, ".valid"}, 32'(bus.VALID), 32'(mon_e.pend != 8'h00));
                chk({mon_e.name, ".z"},     32'(bus.Z),     32'(mon_e.pend != 8'h00));
                chk({mon_e.name, ".lost"},  32'(bus.LOST),  32'(mon_e.lost));
            end
        end
    end

    // Drives one cycle of inputs and records the state expected after the
    // next rising edge.
    task automatic cycle(input logic r, input logic [7:0] a, input logic ack,
                         input string name, input logic [7:0] pend,
                         input logic [2:0] idx, input logic [3:0] lost);
        exp_t e;
        rst     = r;
        bus.A   = a;
        bus.ACK = ack;
        e.cyc   = cyc + 1;
        e.name  = name;
        e.pend  = pend;
        e.idx   = idx;
        e.lost  = lost;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sat15(input int v);
        return 4'((v > 15) ? 15 : v);
    endfunction

    initial begin
        rst     = 1'b1;
        bus.A   = '0;
        bus.ACK = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1, 8'h00, 0, "reset",        8'h00, 3'd0, 4'd0);

        // Single pulse, then acknowledge
        cycle(0, 8'h20, 0, "a5_set",       8'h20, 3'd5, 4'd0);
        cycle(0, 8'h00, 1, "a5_ack",       8'h00, 3'd0, 4'd0);
        cycle(0, 8'h00, 1, "ack_idle",     8'h00, 3'd0, 4'd0);

        // Two sources at once, drained in ascending order while A stays high
        cycle(0, 8'h81, 0, "x81_set",      8'h81, 3'd0, 4'd0);
        cycle(0, 8'h81, 1, "x81_drain0",   8'h80, 3'd7, 4'd0);
        cycle(0, 8'h81, 1, "x81_drain7",   8'h00, 3'd0, 4'd0);
        cycle(0, 8'h81, 0, "held_no_set",  8'h00, 3'd0, 4'd0);
        cycle(0, 8'h00, 0, "x81_release",  8'h00, 3'd0, 4'd0);

        // Lost event on pending bit 3 while ACK retires bit 1
        cycle(0, 8'h0A, 0, "x0a_set",      8'h0A, 3'd1, 4'd0);
        cycle(0, 8'h00, 0, "x0a_hold",     8'h0A, 3'd1, 4'd0);
        cycle(0, 8'h08, 1, "lost_first",   8'h08, 3'd3, 4'd1);
        for (int i = 0; i < 19; i++) begin
            cycle(0, 8'h00, 0, "lost_fall",   8'h08, 3'd3, sat15(1 + i));
            cycle(0, 8'h08, 0, "lost_rise",   8'h08, 3'd3, sat15(2 + i));
        end

        // Reset while sources are pending, with A[0] held through reset
        cycle(0, 8'h00, 0, "pre_fill",     8'h08, 3'd3, 4'd15);
        cycle(0, 8'hF7, 0, "fill_ff",      8'hFF, 3'd0, 4'd15);
        cycle(1, 8'h01, 0, "mid_reset",    8'h00, 3'd0, 4'd0);
        cycle(0, 8'h01, 0, "post_reset",   8'h01, 3'd0, 4'd0);
        cycle(0, 8'h01, 1, "post_ack",     8'h00, 3'd0, 4'd0);

        // Set beats clear on the acknowledged bit
        cycle(0, 8'h04, 0, "a2_set",       8'h04, 3'd2, 4'd0);
        cycle(0, 8'h00, 0, "a2_low",       8'h04, 3'd2, 4'd0);
        cycle(0, 8'h04, 1, "a2_set_clr",   8'h04, 3'd2, 4'd0);
        cycle(0, 8'h00, 1, "a2_drain",     8'h00, 3'd0, 4'd0);

        // Several lost events in one cycle
        cycle(0, 8'h07, 0, "x07_set",      8'h07, 3'd0, 4'd0);
        cycle(0, 8'h00, 0, "x07_low",      8'h07, 3'd0, 4'd0);
        cycle(0, 8'h07, 1, "multi_lost",   8'h07, 3'd0, 4'd2);
        cycle(0, 8'h00, 1, "drain_1",      8'h06, 3'd1, 4'd2);
        cycle(0, 8'h00, 1, "drain_2",      8'h04, 3'd2, 4'd2);
        cycle(0, 8'h00, 1, "drain_3",      8'h00, 3'd0, 4'd2);
        cycle(0, 8'h00, 0, "idle_end",     8'h00, 3'd0, 4'd2);

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
